// File: rtl/uart_tx_cfg.sv
// Parametrised UART transmitter with per-frame captured data width, parity, stop bits and baud divider.
// All outputs are registered and computed from the next-state values, so they line up with the FSM state.
module uart_tx_cfg #(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_W      = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  Data_Valid,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP2,
  input  logic [DIV_W-1:0]      BAUD_DIV,
  output logic                  TX_OUT,
  output logic                  busy,
  output logic                  tx_done
);

  localparam int BW = $clog2(DATA_WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

  state_t                state_r, state_s;
  logic [DIV_W-1:0]      baud_cnt_r, baud_cnt_s;
  logic [BW-1:0]         bit_cnt_r, bit_cnt_s;
  logic [DATA_WIDTH-1:0] shift_r, shift_s;
  logic                  par_en_r, par_en_s;
  logic                  par_bit_r, par_bit_s;
  logic                  stop2_r, stop2_s;
  logic [DIV_W-1:0]      div_r, div_s;
  logic                  tx_out_r, tx_out_s;
  logic                  busy_r, busy_s;
  logic                  tx_done_r, tx_done_s;
  logic                  baud_end_s;

  // Next-state, counter and capture logic for the frame sequencer
  always_comb begin
    state_s    = state_r;
    baud_cnt_s = baud_cnt_r;
    bit_cnt_s  = bit_cnt_r;
    shift_s    = shift_r;
    par_en_s   = par_en_r;
    par_bit_s  = par_bit_r;
    stop2_s    = stop2_r;
    div_s      = div_r;
    baud_end_s = (baud_cnt_r == div_r);
    case (state_r)
      IDLE: begin
        if (Data_Valid) begin
          state_s    = START;
          baud_cnt_s = {DIV_W{1'b0}};
          bit_cnt_s  = {BW{1'b0}};
          shift_s    = P_DATA;
          par_en_s   = PAR_EN;
          par_bit_s  = calc_parity(P_DATA, PAR_TYP);
          stop2_s    = STOP2;
          div_s      = BAUD_DIV;
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        if (baud_end_s) begin
          state_s    = DATA;
          baud_cnt_s = {DIV_W{1'b0}};
          bit_cnt_s  = {BW{1'b0}};
        end else begin
          baud_cnt_s = baud_cnt_r + DIV_W'(1);
        end
      end
      DATA: begin
        if (baud_end_s) begin
          baud_cnt_s = {DIV_W{1'b0}};
          shift_s    = shift_r >> 1;
          if (bit_cnt_r == LAST_BIT) begin
            bit_cnt_s = {BW{1'b0}};
            state_s   = par_en_r ? PARITY : STOP;
          end else begin
            bit_cnt_s = bit_cnt_r + BW'(1);
          end
        end else begin
          baud_cnt_s = baud_cnt_r + DIV_W'(1);
        end
      end
      PARITY: begin
        if (baud_end_s) begin
          state_s    = STOP;
          baud_cnt_s = {DIV_W{1'b0}};
          bit_cnt_s  = {BW{1'b0}};
        end else begin
          baud_cnt_s = baud_cnt_r + DIV_W'(1);
        end
      end
      STOP: begin
        // bit_cnt_r counts stop-bit periods here: 0 for the first, 1 for the optional second
        if (baud_end_s) begin
          baud_cnt_s = {DIV_W{1'b0}};
          if (bit_cnt_r == BW'(stop2_r)) begin
            state_s   = IDLE;
            bit_cnt_s = {BW{1'b0}};
          end else begin
            bit_cnt_s = bit_cnt_r + BW'(1);
          end
        end else begin
          baud_cnt_s = baud_cnt_r + DIV_W'(1);
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Output values for the upcoming cycle, derived from the next state
  always_comb begin
    tx_out_s = 1'b1;
    case (state_s)
      IDLE:    tx_out_s = 1'b1;
      START:   tx_out_s = 1'b0;
      DATA:    tx_out_s = shift_s[0];
      PARITY:  tx_out_s = par_bit_s;
      STOP:    tx_out_s = 1'b1;
      default: tx_out_s = 1'b1;
    endcase
    busy_s    = (state_s != IDLE);
    tx_done_s = (state_s == STOP) && (baud_cnt_s == div_s) && (bit_cnt_s == BW'(stop2_s));
  end

  // State, capture and output registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r    <= IDLE;
      baud_cnt_r <= {DIV_W{1'b0}};
      bit_cnt_r  <= {BW{1'b0}};
      shift_r    <= {DATA_WIDTH{1'b0}};
      par_en_r   <= 1'b0;
      par_bit_r  <= 1'b0;
      stop2_r    <= 1'b0;
      div_r      <= {DIV_W{1'b0}};
      tx_out_r   <= 1'b1;
      busy_r     <= 1'b0;
      tx_done_r  <= 1'b0;
    end else begin
      state_r    <= state_s;
      baud_cnt_r <= baud_cnt_s;
      bit_cnt_r  <= bit_cnt_s;
      shift_r    <= shift_s;
      par_en_r   <= par_en_s;
      par_bit_r  <= par_bit_s;
      stop2_r    <= stop2_s;
      div_r      <= div_s;
      tx_out_r   <= tx_out_s;
      busy_r     <= busy_s;
      tx_done_r  <= tx_done_s;
    end
  end

  assign TX_OUT  = tx_out_r;
  assign busy    = busy_r;
  assign tx_done = tx_done_r;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Scoreboard bench for uart_tx_cfg: stimulus queues expected line waveforms, a negedge monitor
// captures each frame while busy is high and compares length, waveform, tx_done timing and gaps.
module tb_uart_tx_cfg;
  localparam int DW   = 8;
  localparam int DIVW = 16;

  logic            CLK = 1'b0;
  logic            RST = 1'b1;
  logic            Data_Valid = 1'b0;
  logic [DW-1:0]   P_DATA = '0;
  logic            PAR_EN = 1'b0;
  logic            PAR_TYP = 1'b0;
  logic            STOP2 = 1'b0;
  logic [DIVW-1:0] BAUD_DIV = '0;
  logic            TX_OUT;
  logic            busy;
  logic            tx_done;

  uart_tx_cfg #(.DATA_WIDTH(DW), .DIV_W(DIVW)) dut (
    .CLK(CLK), .RST(RST), .Data_Valid(Data_Valid), .P_DATA(P_DATA),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .STOP2(STOP2), .BAUD_DIV(BAUD_DIV),
    .TX_OUT(TX_OUT), .busy(busy), .tx_done(tx_done)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [127:0] wave;
    int           len;
    int           gap;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Build the expected line waveform; len_hand is the hand-computed busy length
  task automatic push_exp(input logic [DW-1:0] data, input logic pe, input logic par,
                          input logic s2, input int div, input int len_hand, input int gap);
    exp_t e;
    logic [15:0] b;
    int nb;
    b = '0;
    nb = 1;
    for (int i = 0; i < DW; i++) begin
      b[nb] = data[i];
      nb++;
    end
    if (pe) begin
      b[nb] = par;
      nb++;
    end
    b[nb] = 1'b1;
    nb++;
    if (s2) begin
      b[nb] = 1'b1;
      nb++;
    end
    e.wave = '0;
    for (int c = 0; c < nb * (div + 1); c++) e.wave[c] = b[c / (div + 1)];
    e.len = len_hand;
    e.gap = gap;
    q.push_back(e);
  endtask

  task automatic wait_busy(input logic v, input string name);
    for (int i = 0; i < 2000; i++) begin
      if (busy === v) return;
      @(posedge CLK);
      #1;
    end
    chk(name, busy, v);
  endtask

  task automatic drive(input logic [DW-1:0] data, input logic pe, input logic pt,
                       input logic s2, input int div);
    P_DATA   = data;
    PAR_EN   = pe;
    PAR_TYP  = pt;
    STOP2    = s2;
    BAUD_DIV = DIVW'(div);
  endtask

  task automatic send(input logic [DW-1:0] data, input logic pe, input logic pt, input logic s2,
                      input int div, input logic par, input int len_hand);
    wait_busy(1'b0, "wait_idle");
    push_exp(data, pe, par, s2, div, len_hand, -1);
    drive(data, pe, pt, s2, div);
    Data_Valid = 1'b1;
    @(posedge CLK);
    #1;
    chk("accept", busy, 1'b1);
    Data_Valid = 1'b0;
  endtask

  // Monitor: captures each busy window and compares it against the queue head
  initial begin
    exp_t cur;
    logic [127:0] wave;
    int cyc, done_cnt, done_idx, idle_cnt;
    logic prev_busy, active;
    prev_busy = 1'b0; active = 1'b0; idle_cnt = 0;
    cyc = 0; done_cnt = 0; done_idx = -1; wave = '0;
    forever begin
      @(negedge CLK);
      if (RST) begin
        active = 1'b0; prev_busy = 1'b0; idle_cnt = 0;
      end else begin
        if (busy && !prev_busy) begin
          if (q.size() == 0) begin
            chk("unexpected_frame", 128'd1, 128'd0);
            active = 1'b0;
          end else begin
            cur = q.pop_front();
            if (cur.gap >= 0) chk("idle_gap", idle_cnt, cur.gap);
            active = 1'b1; cyc = 0; wave = '0; done_cnt = 0; done_idx = -1;
          end
        end
        if (busy && active) begin
          if (cyc < 128) wave[cyc] = TX_OUT;
          if (tx_done) begin
            done_cnt++;
            done_idx = cyc;
          end
          cyc++;
        end
        if (!busy && prev_busy && active) begin
          chk("frame_len", cyc, cur.len);
          chk("frame_wave", wave, cur.wave);
          chk("done_idx", done_idx, cur.len - 1);
          chk("done_cnt", done_cnt, 1);
          chk("idle_tx", TX_OUT, 1'b1);
          active = 1'b0;
          idle_cnt = 0;
        end
        if (!busy) idle_cnt++;
        prev_busy = busy;
      end
    end
  end

  // Directed stimulus
  initial begin
    #12;
    chk("rst_tx", TX_OUT, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", tx_done, 1'b0);
    @(posedge CLK);
    #3;
    RST = 1'b0;
    @(posedge CLK);
    #1;

    // 0xA5 even parity, div 0: 0,1,0,1,0,0,1,0,1,0,1 over 11 cycles
    send(8'hA5, 1'b1, 1'b0, 1'b0, 0, 1'b0, 11);
    // 0x07 odd -> parity 0, even -> parity 1
    send(8'h07, 1'b1, 1'b1, 1'b0, 0, 1'b0, 11);
    send(8'h07, 1'b1, 1'b0, 1'b0, 0, 1'b1, 11);
    // div 3, no parity: 40 cycles, 44 with two stop bits
    send(8'h3C, 1'b0, 1'b0, 1'b0, 3, 1'b0, 40);
    send(8'h3C, 1'b0, 1'b0, 1'b1, 3, 1'b0, 44);

    // Back-to-back with Data_Valid held high: one idle CLK between frames
    wait_busy(1'b0, "wait_idle");
    push_exp(8'h55, 1'b0, 1'b0, 1'b0, 0, 10, -1);
    push_exp(8'hAA, 1'b0, 1'b0, 1'b0, 0, 10, 1);
    drive(8'h55, 1'b0, 1'b0, 1'b0, 0);
    Data_Valid = 1'b1;
    @(posedge CLK);
    #1;
    chk("accept_b2b1", busy, 1'b1);
    P_DATA = 8'hAA;
    wait_busy(1'b0, "wait_b2b_idle");
    @(posedge CLK);
    #1;
    chk("accept_b2b2", busy, 1'b1);
    Data_Valid = 1'b0;

    // Mid-frame retune: 0x96 odd parity -> 1, div 2 (33 cycles); then 0x01, no parity, 2 stops, div 0
    send(8'h96, 1'b1, 1'b1, 1'b0, 2, 1'b1, 33);
    repeat (4) @(posedge CLK);
    #1;
    drive(8'h01, 1'b0, 1'b0, 1'b1, 0);
    send(8'h01, 1'b0, 1'b0, 1'b1, 0, 1'b0, 11);

    // Async reset during data bit 3 of 0x00 at div 1 (bit 3 spans cycles 9-10 of the frame)
    send(8'h00, 1'b0, 1'b0, 1'b0, 1, 1'b0, 20);
    repeat (8) @(posedge CLK);
    #2;
    chk("pre_rst_busy", busy, 1'b1);
    chk("pre_rst_tx", TX_OUT, 1'b0);
    RST = 1'b1;
    #1;
    chk("mid_rst_tx", TX_OUT, 1'b1);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_done", tx_done, 1'b0);
    @(posedge CLK);
    #3;
    RST = 1'b0;
    @(posedge CLK);
    #1;
    // Clean frame after reset: 0xC3 even parity -> 0
    send(8'hC3, 1'b1, 1'b0, 1'b0, 0, 1'b0, 11);

    wait_busy(1'b0, "wait_final");
    repeat (3) @(posedge CLK);
    #1;
    chk("queue_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
